// File: rtl/eb_arb_merge.sv
// eb_arb_merge: round-robin N-to-1 req/ack merge into a 2-entry elastic buffer.
// Optional EB_ARB_LOCK_EN: bit DW-1 is a last flag; grant locks to a channel until last.
module eb_arb_merge #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int SW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    t_req,
  output logic [N-1:0]    t_ack,
  input  logic [N*DW-1:0] t_data,
  output logic            i_req,
  input  logic            i_ack,
  output logic [DW-1:0]   i_data,
  output logic [SW-1:0]   i_src
);

  logic [SW+DW-1:0] mem [2];
  logic [1:0]       count;
  logic [1:0]       count_nx;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             full;
  logic [SW-1:0]    rr_ptr;
  logic [SW-1:0]    rr_nx;
  logic [N-1:0]     grant;
  logic [SW-1:0]    gidx;
  logic [SW-1:0]    cand;
  logic             found;
  logic [DW-1:0]    sel_data;
  logic             push;
  logic             pop;

`ifdef EB_ARB_LOCK_EN
  logic             lock_q;
  logic [SW-1:0]    lock_idx;
`endif

  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = SW'((int'(rr_ptr) + i) % N);
      if (!found && t_req[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
`ifdef EB_ARB_LOCK_EN
    // A locked channel owns the grant until its last beat goes through.
    if (lock_q) begin
      found = t_req[lock_idx];
      gidx  = lock_idx;
    end
`endif
    if (found) grant[gidx] = 1'b1;
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (gidx == SW'(k)) sel_data = t_data[k*DW +: DW];
    end
  end

  assign t_ack = grant & {N{~full & ~reset}};
  assign push  = found & ~full & ~reset;
  assign pop   = i_req & i_ack;
  assign i_req = (count != 2'd0);
  assign {i_src, i_data} = mem[rd_ptr];
  assign rr_nx = (gidx == SW'(N-1)) ? '0 : gidx + SW'(1);

  always_comb begin
    count_nx = count;
    unique case (1'b1)
      push & ~pop: count_nx = count + 2'd1;
      pop & ~push: count_nx = count - 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      full   <= 1'b0;
      rr_ptr <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
`ifdef EB_ARB_LOCK_EN
      lock_q   <= 1'b0;
      lock_idx <= '0;
`endif
    end else begin
      count <= count_nx;
      full  <= (count_nx == 2'd2);
      if (push) begin
        mem[wr_ptr] <= {gidx, sel_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
`ifdef EB_ARB_LOCK_EN
      if (push) begin
        if (sel_data[DW-1]) begin
          lock_q <= 1'b0;
          rr_ptr <= rr_nx;
        end else begin
          lock_q   <= 1'b1;
          lock_idx <= gidx;
        end
      end
`else
      if (push) rr_ptr <= rr_nx;
`endif
    end
  end

endmodule

// File: tb/tb_eb_arb_merge.sv
// tb_eb_arb_merge: directed checks of eb_arb_merge arbitration and buffering.
// Honors EB_ARB_LOCK_EN for the packet-lock expectations.
module tb_eb_arb_merge;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   t_req;
  logic [3:0]   t_ack;
  logic [127:0] t_data;
  logic         i_req;
  logic         i_ack;
  logic [31:0]  i_data;
  logic [1:0]   i_src;

  int total = 0;
  int fails = 0;

  eb_arb_merge #(.N(4), .DW(32), .SW(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .t_req  (t_req),
    .t_ack  (t_ack),
    .t_data (t_data),
    .i_req  (i_req),
    .i_ack  (i_ack),
    .i_data (i_data),
    .i_src  (i_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] c0 [3];
  logic [1:0]  exp_src [4];
  logic [31:0] exp_dat [4];
  logic [3:0]  acked;
  int          b0;

  initial begin
    reset  = 1'b1;
    t_req  = 4'hF;
    i_ack  = 1'b0;
    t_data = '0;
    for (int k = 0; k < 4; k++) t_data[k*32 +: 32] = 32'h100 + k;
    tick();
    tick();
    check("rst_tack", t_ack, 0);
    check("rst_ireq", i_req, 0);
    check("rst_idata", i_data, 0);
    check("rst_isrc", i_src, 0);

    reset = 1'b0;
    i_ack = 1'b1;
    #1;
    check("first_ack", t_ack, 4'b0001);

    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("rr_ireq%0d", i), i_req, 1);
      check($sformatf("rr_src%0d", i), i_src, i % 4);
      check($sformatf("rr_dat%0d", i), i_data, 32'h100 + (i % 4));
    end
    t_req = 4'b0000;
    tick();
    check("rr_drain", i_req, 0);

    i_ack = 1'b0;
    t_req = 4'b0100;
    t_data[64 +: 32] = 32'hA0;
    #1;
    check("bp_ack0", t_ack, 4'b0100);
    tick();
    t_data[64 +: 32] = 32'hA1;
    check("bp_ack1", t_ack, 4'b0100);
    check("bp_head0", i_data, 32'hA0);
    tick();
    t_data[64 +: 32] = 32'hA2;
    check("bp_full", t_ack, 4'b0000);
    check("bp_ireq", i_req, 1);
    tick();
    check("bp_hold", t_ack, 4'b0000);
    check("bp_head1", i_data, 32'hA0);
    check("bp_src", i_src, 2);
    i_ack = 1'b1;
    tick();
    check("bp_pop1", i_data, 32'hA1);
    check("bp_recov", t_ack, 4'b0100);
    tick();
    t_req = 4'b0000;
    check("bp_pop2", i_data, 32'hA2);
    tick();
    check("bp_empty", i_req, 0);

    t_req = 4'b0010;
    t_data[32 +: 32] = 32'h55;
    #1;
    check("s1_ireq0", i_req, 0);
    check("s1_ack", t_ack, 4'b0010);
    tick();
    check("s1_ireq1", i_req, 1);
    check("s1_dat", i_data, 32'h55);
    check("s1_src", i_src, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("s1_ss_req%0d", i), i_req, 1);
      check($sformatf("s1_ss_ack%0d", i), t_ack, 4'b0010);
    end
    t_req = 4'b0000;
    tick();
    check("s1_drain", i_req, 0);

    i_ack = 1'b0;
    t_req = 4'b0001;
    t_data[0 +: 32] = 32'h11;
    tick();
    t_data[0 +: 32] = 32'h12;
    tick();
    check("mr_ireq", i_req, 1);
    check("mr_full", t_ack, 4'b0000);
    reset = 1'b1;
    t_req = 4'b0000;
    tick();
    check("mr_ireq0", i_req, 0);
    check("mr_dat0", i_data, 0);
    check("mr_ack0", t_ack, 4'b0000);
    reset = 1'b0;
    i_ack = 1'b1;
    tick();
    check("mr_stale0", i_req, 0);
    tick();
    check("mr_stale1", i_req, 0);

    c0[0] = 32'h0000_0C00;
    c0[1] = 32'h0000_0C01;
    c0[2] = 32'h8000_0C02;
`ifdef EB_ARB_LOCK_EN
    exp_src[0] = 2'd0; exp_dat[0] = c0[0];
    exp_src[1] = 2'd0; exp_dat[1] = c0[1];
    exp_src[2] = 2'd0; exp_dat[2] = c0[2];
    exp_src[3] = 2'd1; exp_dat[3] = 32'h8000_0B01;
`else
    exp_src[0] = 2'd0; exp_dat[0] = c0[0];
    exp_src[1] = 2'd1; exp_dat[1] = 32'h8000_0B01;
    exp_src[2] = 2'd0; exp_dat[2] = c0[1];
    exp_src[3] = 2'd0; exp_dat[3] = c0[2];
`endif
    b0 = 0;
    t_data[0 +: 32]  = c0[0];
    t_data[32 +: 32] = 32'h8000_0B01;
    t_req = 4'b0011;
    for (int s = 0; s < 4; s++) begin
      #1;
      acked = t_ack;
      tick();
      if (acked[0]) begin
        b0++;
        if (b0 == 3) t_req[0] = 1'b0;
        else t_data[0 +: 32] = c0[b0];
      end
      if (acked[1]) t_req[1] = 1'b0;
      check($sformatf("lk_src%0d", s), i_src, exp_src[s]);
      check($sformatf("lk_dat%0d", s), i_data, exp_dat[s]);
    end
    t_req = 4'b0000;
    tick();
    check("lk_drain", i_req, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
